// File: rtl/entropy_pool_pkg.sv
// Shared definitions for the entropy pool: LFSR geometry and taps, the
// word-assembly FSM encoding, the per-lane default seed and the LFSR step.
package entropy_pool_pkg;

  localparam int LFSR_W = 64;

  // Feedback taps of x^64 + x^63 + x^61 + x^60 + 1 (bit indices).
  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;

  localparam logic [LFSR_W-1:0] SEED_BASE = 64'hACE1_5EED_0BAD_F00D;

  typedef enum logic [1:0] {
    ST_GATHER = 2'd0,
    ST_CHECK  = 2'd1,
    ST_STALL  = 2'd2
  } pool_state_e;

  // Each lane gets a distinct nonzero default so lanes never run in lockstep.
  function automatic logic [LFSR_W-1:0] default_seed(input int lane);
    return SEED_BASE ^ LFSR_W'(lane);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/entropy_fifo.sv
// First-word-fall-through FIFO with occupancy count.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data (ignored when full without a pop)
//   pop           : read request (ignored when empty)
//   dout, valid   : head word (zero when empty) and non-empty flag
//   count         : current occupancy, 0..DEPTH
module entropy_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // valid comes from the registered count only, so ready never reaches it.
  assign valid = (cnt_q != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/entropy_pool.sv
// Entropy pool: NUM_LANES 64-bit Fibonacci LFSRs feed an assembly register;
// each completed word passes a repetition test and is buffered in a FWFT FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : generation enable (FIFO pops continue when low)
//   seed_we, seed_i : one-cycle reseed strobe, lane k from seed_i[64k +: 64]
//   data_o, valid_o : head-of-FIFO word and FIFO non-empty
//   ready_i         : consumer accept
//   fill_o          : FIFO occupancy
//   health_fail_o   : sticky repetition-test failure
//   fail_cnt_o      : saturating count of discarded words
//   clr_fail_i      : clears health_fail_o and fail_cnt_o
module entropy_pool
  import entropy_pool_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 256,
  parameter int NUM_LANES    = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            seed_we,
  input  logic [64*NUM_LANES-1:0]         seed_i,
  output logic [OUTPUT_WIDTH-1:0]         data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fill_o,
  output logic                            health_fail_o,
  output logic [7:0]                      fail_cnt_o,
  input  logic                            clr_fail_i
);

  localparam int STEPS  = OUTPUT_WIDTH / NUM_LANES;
  localparam int CNT_W  = $clog2(STEPS + 1);
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  if (OUTPUT_WIDTH % NUM_LANES != 0) begin : g_chk_width
    $error("entropy_pool: OUTPUT_WIDTH must be a multiple of NUM_LANES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("entropy_pool: FIFO_DEPTH must be a power of two and at least 2");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [LFSR_W-1:0]       lfsr_q [NUM_LANES];
  logic [NUM_LANES-1:0]    lane_bits;
  logic [OUTPUT_WIDTH-1:0] asm_q;
  logic [OUTPUT_WIDTH-1:0] asm_next;
  logic [OUTPUT_WIDTH-1:0] hist_q;
  logic                    hist_vld_q;
  logic [CNT_W-1:0]        cnt_q;
  pool_state_e             state_q;
  logic                    health_q;
  logic [7:0]              fail_cnt_q;
  logic [FILL_W-1:0]       fill;
  logic                    pop;
  logic                    can_push;
  logic                    is_repeat;
  logic                    run;
  logic                    gather;
  logic                    push;
  logic                    fail_evt;

  always_comb begin
    lane_bits = '0;
    for (int k = 0; k < NUM_LANES; k++) lane_bits[k] = lfsr_q[k][LFSR_W-1];
  end

  // Oldest slice drifts toward the MSBs; lane 0 lands in the LSB of each slice.
  always_comb begin
    asm_next = asm_q << NUM_LANES;
    asm_next[NUM_LANES-1:0] = lane_bits;
  end

  assign pop       = valid_o && ready_i;
  assign can_push  = (fill < FILL_W'(FIFO_DEPTH)) || pop;
  assign is_repeat = hist_vld_q && (asm_q == hist_q);
  // A reseed outranks everything: the pending word is silently dropped.
  assign run       = en && !seed_we;
  assign gather    = run && (state_q == ST_GATHER);
  assign fail_evt  = run && (state_q == ST_CHECK) && is_repeat;
  assign push      = run && can_push &&
                     (((state_q == ST_CHECK) && !is_repeat) || (state_q == ST_STALL));

  // Lane registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANES; k++) lfsr_q[k] <= default_seed(k);
    end else if (seed_we) begin
      for (int k = 0; k < NUM_LANES; k++)
        lfsr_q[k] <= (seed_i[64*k +: 64] == '0) ? default_seed(k) : seed_i[64*k +: 64];
    end else if (gather) begin
      for (int k = 0; k < NUM_LANES; k++) lfsr_q[k] <= lfsr_step(lfsr_q[k]);
    end
  end

  // Assembly register and history
  always_ff @(posedge clk) begin
    if (seed_we)     asm_q <= '0;
    else if (gather) asm_q <= asm_next;
    if (run && (state_q == ST_CHECK) && !is_repeat) hist_q <= asm_q;
  end

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_GATHER;
      cnt_q      <= '0;
      hist_vld_q <= 1'b0;
    end else if (seed_we) begin
      state_q    <= ST_GATHER;
      cnt_q      <= '0;
      hist_vld_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_GATHER: begin
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (is_repeat) begin
            state_q <= ST_GATHER;
          end else begin
            hist_vld_q <= 1'b1;
            state_q    <= can_push ? ST_GATHER : ST_STALL;
          end
        end
        ST_STALL: if (can_push) state_q <= ST_GATHER;
        default:  state_q <= ST_GATHER;
      endcase
    end
  end

  // Health flags: a failure in the same cycle as a clear wins, counting from 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      health_q   <= 1'b0;
      fail_cnt_q <= '0;
    end else if (fail_evt) begin
      health_q   <= 1'b1;
      fail_cnt_q <= clr_fail_i ? 8'd1 : sat_inc8(fail_cnt_q);
    end else if (clr_fail_i) begin
      health_q   <= 1'b0;
      fail_cnt_q <= '0;
    end
  end

  entropy_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (asm_q),
    .pop   (pop),
    .dout  (data_o),
    .valid (valid_o),
    .count (fill)
  );

  assign fill_o        = fill;
  assign health_fail_o = health_q;
  assign fail_cnt_o    = fail_cnt_q;

endmodule

// File: tb/tb_entropy_pool.sv
`timescale 1ns/1ps
module tb_entropy_pool;
  import entropy_pool_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance: 4 lanes, 256-bit words
  logic         en_a, seed_we_a, ready_a, clr_a;
  logic [255:0] seed_a;
  logic [255:0] data_a;
  logic         valid_a, hf_a;
  logic [2:0]   fill_a;
  logic [7:0]   fc_a;

  // Narrow instance: 8 lanes, 64-bit words
  logic         en_b, seed_we_b, ready_b, clr_b;
  logic [511:0] seed_b;
  logic [63:0]  data_b;
  logic         valid_b, hf_b;
  logic [2:0]   fill_b;
  logic [7:0]   fc_b;

  entropy_pool dut (
    .clk(clk), .rst(rst), .en(en_a), .seed_we(seed_we_a), .seed_i(seed_a),
    .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a), .fill_o(fill_a),
    .health_fail_o(hf_a), .fail_cnt_o(fc_a), .clr_fail_i(clr_a)
  );

  entropy_pool #(.OUTPUT_WIDTH(64), .NUM_LANES(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .en(en_b), .seed_we(seed_we_b), .seed_i(seed_b),
    .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b), .fill_o(fill_b),
    .health_fail_o(hf_b), .fail_cnt_o(fc_b), .clr_fail_i(clr_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: bit-serial lanes, word history, expected-word queue
  logic [63:0]  m_st [2][8];
  logic [255:0] m_hist [2];
  bit           m_hvld [2];
  logic [255:0] exp_q [$];
  logic [255:0] w_reset0;

  function automatic int nl_of(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  function automatic int ow_of(input int sel);
    return (sel == 0) ? 256 : 64;
  endfunction

  task automatic model_seed(input int sel, input logic [511:0] s);
    logic [63:0] sl;
    for (int k = 0; k < nl_of(sel); k++) begin
      sl = s[k*64 +: 64];
      m_st[sel][k] = (sl == 64'd0) ? (64'hACE15EED0BADF00D ^ 64'(k)) : sl;
    end
    m_hvld[sel] = 1'b0;
  endtask

  task automatic model_raw(input int sel, output logic [255:0] w);
    logic [63:0] s;
    w = '0;
    for (int t = 0; t < ow_of(sel) / nl_of(sel); t++) begin
      for (int k = nl_of(sel) - 1; k >= 0; k--) begin
        s = m_st[sel][k];
        w = {w[254:0], s[63]};
        m_st[sel][k] = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
      end
    end
  endtask

  task automatic model_next(input int sel, output logic [255:0] w);
    for (int i = 0; i < 4; i++) begin
      model_raw(sel, w);
      if (!(m_hvld[sel] && w == m_hist[sel])) begin
        m_hist[sel] = w;
        m_hvld[sel] = 1'b1;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: en=1 ready=1; mode 1: random en/ready; mode 2: en=0 ready=1
  task automatic run_traffic(input int cycles, input int mode, output int pops);
    logic [255:0] w;
    pops = 0;
    for (int c = 0; c < cycles; c++) begin
      case (mode)
        0: begin en_a = 1'b1; ready_a = 1'b1; end
        1: begin en_a = ($urandom_range(3) != 0); ready_a = 1'($urandom_range(1)); end
        default: begin en_a = 1'b0; ready_a = 1'b1; end
      endcase
      if (valid_a && ready_a) begin
        if (exp_q.size() == 0) begin
          model_next(0, w);
          exp_q.push_back(w);
        end
        checks++;
        if (data_a !== exp_q[0]) begin
          failures++;
          $display("FAIL stream_word got=%h want=%h", data_a, exp_q[0]);
        end
        void'(exp_q.pop_front());
        pops++;
      end
      tick();
    end
  endtask

  function automatic logic [511:0] repeat_seed();
    logic [511:0] s;
    logic [63:0]  l;
    for (int k = 0; k < 8; k++) begin
      l = {$urandom(), $urandom()};
      l[63:56] = l[63:56] | 8'h01;
      l[55:48] = l[63:56];
      s[k*64 +: 64] = l;
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en_a = 0; seed_we_a = 0; ready_a = 0; clr_a = 0; seed_a = '0;
    en_b = 0; seed_we_b = 0; ready_b = 0; clr_b = 0; seed_b = '0;
    repeat (3) tick();
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_a); end
    checks++; if (fill_a !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d want=0", fill_a); end
    checks++; if (data_a !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", data_a); end
    checks++; if (hf_a !== 1'b0 || fc_a !== 8'd0) begin failures++; $display("FAIL reset_health got=%b/%0d want=0/0", hf_a, fc_a); end
    checks++; if (valid_b !== 1'b0 || data_b !== 64'd0) begin failures++; $display("FAIL reset_narrow got=%b/%h want=0/0", valid_b, data_b); end
  endtask

  task automatic test_first_word();
    logic [255:0] w;
    model_seed(0, '0);
    rst = 1'b0; en_a = 1'b1; ready_a = 1'b0;
    repeat (64) tick();
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL first_word_early got=%b want=0", valid_a); end
    tick();
    checks++; if (valid_a !== 1'b1 || fill_a !== 3'd1) begin failures++; $display("FAIL first_word_valid got=%b/%0d want=1/1", valid_a, fill_a); end
    model_next(0, w);
    w_reset0 = w;
    checks++; if (data_a !== w) begin failures++; $display("FAIL first_word_data got=%h want=%h", data_a, w); end
    exp_q.push_back(w);
  endtask

  task automatic test_stall();
    logic [255:0] w;
    int pops;
    for (int i = 0; i < 4; i++) begin
      model_next(0, w);
      exp_q.push_back(w);
    end
    for (int cyc = 66; cyc <= 400; cyc++) begin
      tick();
      if (cyc == 390 || cyc == 400) begin
        checks++;
        if (dut.state_q !== ST_STALL) begin failures++; $display("FAIL stall_state cycle=%0d got=%0d want=%0d", cyc, dut.state_q, ST_STALL); end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (dut.lfsr_q[k] !== m_st[0][k]) begin failures++; $display("FAIL stall_lane%0d got=%h want=%h", k, dut.lfsr_q[k], m_st[0][k]); end
        end
      end
    end
    checks++; if (fill_a !== 3'd4) begin failures++; $display("FAIL stall_fill got=%0d want=4", fill_a); end
    run_traffic(200, 0, pops);
    checks++; if (pops < 7) begin failures++; $display("FAIL stall_resume pops=%0d want>=7", pops); end
  endtask

  task automatic test_reseed_zero();
    int pops;
    run_traffic(10, 2, pops);
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reseed_drain got=%b want=0", valid_a); end
    exp_q.delete();
    en_a = 1'b1; ready_a = 1'b0; seed_a = '0; seed_we_a = 1'b1;
    tick();
    seed_we_a = 1'b0;
    model_seed(0, '0);
    repeat (64) tick();
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reseed_early got=%b want=0", valid_a); end
    tick();
    checks++; if (valid_a !== 1'b1 || data_a !== w_reset0) begin failures++; $display("FAIL reseed_word got=%h want=%h", data_a, w_reset0); end
    begin
      logic [255:0] w;
      model_next(0, w);
      exp_q.push_back(w);
    end
  endtask

  task automatic test_seed_on_complete();
    logic [255:0] s;
    int pops;
    repeat (63) tick();
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    seed_a = s; seed_we_a = 1'b1;
    tick();
    seed_we_a = 1'b0;
    model_seed(0, {256'd0, s});
    checks++; if (fill_a !== 3'd1) begin failures++; $display("FAIL seedcomp_fill got=%0d want=1", fill_a); end
    checks++; if (fc_a !== 8'd0 || hf_a !== 1'b0) begin failures++; $display("FAIL seedcomp_fail got=%b/%0d want=0/0", hf_a, fc_a); end
    repeat (64) tick();
    checks++; if (fill_a !== 3'd1) begin failures++; $display("FAIL seedcomp_restart_early got=%0d want=1", fill_a); end
    tick();
    checks++; if (fill_a !== 3'd2) begin failures++; $display("FAIL seedcomp_restart got=%0d want=2", fill_a); end
    run_traffic(10, 0, pops);
    checks++; if (pops !== 2) begin failures++; $display("FAIL seedcomp_pops got=%0d want=2", pops); end
  endtask

  task automatic test_random_streams();
    logic [255:0] s;
    int pops;
    for (int r = 0; r < 3; r++) begin
      run_traffic(10, 2, pops);
      checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL rand_drain%0d got=%b want=0", r, valid_a); end
      exp_q.delete();
      s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (r == 1) s[128 +: 64] = 64'd0;
      en_a = 1'b1; seed_a = s; seed_we_a = 1'b1;
      tick();
      seed_we_a = 1'b0;
      model_seed(0, {256'd0, s});
      run_traffic(400, 1, pops);
      run_traffic(150, 0, pops);
    end
    run_traffic(10, 2, pops);
  endtask

  task automatic test_narrow();
    logic [255:0] w;
    model_seed(1, '0);
    en_b = 1'b1; ready_b = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      tick();
      checks++;
      if (c % 9 == 0) begin
        model_next(1, w);
        if (valid_b !== 1'b1 || data_b !== w[63:0]) begin failures++; $display("FAIL narrow_word cycle=%0d got=%b/%h want=1/%h", c, valid_b, data_b, w[63:0]); end
      end else begin
        if (valid_b !== 1'b0) begin failures++; $display("FAIL narrow_gap cycle=%0d got=%b want=0", c, valid_b); end
      end
    end
    en_b = 1'b0;
    tick();
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL narrow_drain got=%b want=0", valid_b); end
  endtask

  task automatic test_repeat();
    logic [511:0] s;
    logic [255:0] wa, wb;
    s = repeat_seed();
    ready_b = 1'b0; en_b = 1'b1; seed_b = s; seed_we_b = 1'b1;
    tick();
    seed_we_b = 1'b0;
    model_seed(1, s);
    model_raw(1, wa);
    model_raw(1, wb);
    repeat (9) tick();
    checks++; if (fill_b !== 3'd1 || data_b !== wa[63:0]) begin failures++; $display("FAIL repeat_first got=%0d/%h want=1/%h", fill_b, data_b, wa[63:0]); end
    checks++; if (hf_b !== 1'b0) begin failures++; $display("FAIL repeat_early_flag got=%b want=0", hf_b); end
    repeat (9) tick();
    checks++; if (hf_b !== 1'b1 || fc_b !== 8'd1) begin failures++; $display("FAIL repeat_flag got=%b/%0d want=1/1", hf_b, fc_b); end
    checks++; if (fill_b !== 3'd1) begin failures++; $display("FAIL repeat_discard got=%0d want=1", fill_b); end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checks++; if (hf_b !== 1'b0 || fc_b !== 8'd0) begin failures++; $display("FAIL repeat_clear got=%b/%0d want=0/0", hf_b, fc_b); end
    s = repeat_seed();
    seed_b = s; seed_we_b = 1'b1;
    tick();
    seed_we_b = 1'b0;
    repeat (17) tick();
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checks++; if (hf_b !== 1'b1 || fc_b !== 8'd1) begin failures++; $display("FAIL repeat_clr_collide got=%b/%0d want=1/1", hf_b, fc_b); end
    checks++; if (fill_b !== 3'd2) begin failures++; $display("FAIL repeat_collide_fill got=%0d want=2", fill_b); end
  endtask

  task automatic test_reset_mid_word();
    en_a = 1'b1; ready_a = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    checks++; if (valid_a !== 1'b0 || fill_a !== 3'd0) begin failures++; $display("FAIL midreset_empty got=%b/%0d want=0/0", valid_a, fill_a); end
    rst = 1'b0;
    model_seed(0, '0);
    exp_q.delete();
    repeat (64) tick();
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL midreset_early got=%b want=0", valid_a); end
    tick();
    checks++; if (valid_a !== 1'b1 || data_a !== w_reset0) begin failures++; $display("FAIL midreset_word got=%h want=%h", data_a, w_reset0); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_word();
    test_stall();
    test_reseed_zero();
    test_seed_on_complete();
    test_random_streams();
    test_narrow();
    test_repeat();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
